// File: rtl/cv32e40p_trace_buffer.sv
// cv32e40p_trace_buffer: triggered capture FIFO of retired-instruction records
module cv32e40p_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter bit WRAP   = 1'b0,
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trace_en_i,
  input  logic                     trigger_en_i,
  input  logic [31:0]              trigger_pc_i,
  input  logic                     valid_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     clear_i,
  input  logic                     rd_req_i,
  output logic                     rd_valid_o,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_instr_o,
  output logic [31:0]              rd_wdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [1:0]               state_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FROZEN} state_t;
  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [95:0]       mem [DEPTH];
  logic              cap_ev, push, pop, full, drop, wr_en;
  assign cap_ev = valid_i && (!trigger_en_i || pc_i == trigger_pc_i);
  assign push   = (state_q == CAPTURE && valid_i) || (state_q == ARMED && cap_ev);
  assign pop    = rd_req_i && count_q != '0;
  assign full   = count_q == (AW+1)'(DEPTH);
  // a push into a full buffer with no pop to make room loses (or overwrites) a record
  assign drop   = push && full && !pop;
  assign wr_en  = push && !clear_i && !(drop && !WRAP);
  // next state: clear re-arms or idles, trace disable wins over all other transitions
  always_comb begin
    state_d = state_q;
    if (clear_i) state_d = trace_en_i ? ARMED : IDLE;
    else if (!trace_en_i) state_d = IDLE;
    else if (state_q == IDLE) state_d = ARMED;
    else if (state_q == ARMED) state_d = cap_ev ? CAPTURE : ARMED;
    else if (state_q == CAPTURE) state_d = (drop && !WRAP) ? FROZEN : CAPTURE;
  end
  // control state: pointers, occupancy, overflow bookkeeping and FSM register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      state_q    <= state_d;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop || (drop && WRAP)) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop && !full) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end
  // record storage needs no reset; contents are only meaningful while count is nonzero
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= {pc_i, instr_i, wdata_i};
  end
  assign {rd_pc_o, rd_instr_o, rd_wdata_o} = mem[rd_ptr_q];
  assign rd_valid_o = count_q != '0;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// tb_cv32e40p_trace_buffer: directed checks of capture, stop/wrap overflow, clear and reset
module tb_cv32e40p_trace_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic trace_en = 1'b0, trigger_en = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [31:0] trigger_pc = '0, pc = '0;
  logic rd0 = 1'b0, rd1 = 1'b0, rd2 = 1'b0;
  logic rv0, rv1, rv2, ov0, ov1, ov2;
  logic [31:0] rp0, rp1, rp2, ri0, ri1, ri2, rw0, rw1, rw2;
  logic [2:0] c0, c1;
  logic [1:0] c2, s0, s1, s2, d2;
  logic [15:0] d0, d1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cv32e40p_trace_buffer #(.DEPTH(4), .WRAP(1'b0), .DROP_W(16)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en), .trigger_en_i(trigger_en),
    .trigger_pc_i(trigger_pc), .valid_i(valid), .pc_i(pc), .instr_i(pc ^ 32'hA5A5_0000),
    .wdata_i(pc + 32'd1), .clear_i(clear), .rd_req_i(rd0), .rd_valid_o(rv0),
    .rd_pc_o(rp0), .rd_instr_o(ri0), .rd_wdata_o(rw0), .count_o(c0),
    .overflow_o(ov0), .drop_cnt_o(d0), .state_o(s0));
  cv32e40p_trace_buffer #(.DEPTH(4), .WRAP(1'b1), .DROP_W(16)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en), .trigger_en_i(trigger_en),
    .trigger_pc_i(trigger_pc), .valid_i(valid), .pc_i(pc), .instr_i(pc ^ 32'hA5A5_0000),
    .wdata_i(pc + 32'd1), .clear_i(clear), .rd_req_i(rd1), .rd_valid_o(rv1),
    .rd_pc_o(rp1), .rd_instr_o(ri1), .rd_wdata_o(rw1), .count_o(c1),
    .overflow_o(ov1), .drop_cnt_o(d1), .state_o(s1));
  cv32e40p_trace_buffer #(.DEPTH(2), .WRAP(1'b1), .DROP_W(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en), .trigger_en_i(trigger_en),
    .trigger_pc_i(trigger_pc), .valid_i(valid), .pc_i(pc), .instr_i(pc ^ 32'hA5A5_0000),
    .wdata_i(pc + 32'd1), .clear_i(clear), .rd_req_i(rd2), .rd_valid_o(rv2),
    .rd_pc_o(rp2), .rd_instr_o(ri2), .rd_wdata_o(rw2), .count_o(c2),
    .overflow_o(ov2), .drop_cnt_o(d2), .state_o(s2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p);
    valid = 1'b1;
    pc = p;
    cycle();
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    chk("rst_state", s0, 0);
    chk("rst_count", c0, 0);
    chk("rst_valid", rv0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_drop", d0, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("idle_hold", s0, 0);

    // trigger on PC 0x100
    trace_en = 1'b1; trigger_en = 1'b1; trigger_pc = 32'h100;
    cycle();
    chk("armed", s0, 1);
    push(32'hF8);
    push(32'hFC);
    chk("no_trig_count", c0, 0);
    push(32'h100);
    push(32'h104);
    chk("trig_count", c0, 2);
    chk("trig_pc", rp0, 32'h100);
    chk("trig_instr", ri0, 32'h100 ^ 32'hA5A5_0000);
    chk("trig_wdata", rw0, 32'h101);
    chk("trig_state", s0, 2);

    // stop mode (u0) vs wrap mode (u1) vs saturating small counter (u2)
    clear = 1'b1; trigger_en = 1'b0;
    cycle();
    clear = 1'b0;
    chk("clear_armed", s0, 1);
    chk("clear_count", c0, 0);
    for (int i = 0; i < 6; i++) push(32'(i * 4));
    chk("stop_count", c0, 4);
    chk("stop_drop", d0, 1);
    chk("stop_ovf", ov0, 1);
    chk("stop_state", s0, 3);
    chk("stop_pc", rp0, 0);
    chk("wrap_count", c1, 4);
    chk("wrap_drop", d1, 2);
    chk("wrap_ovf", ov1, 1);
    rd1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_pop_pc", rp1, 32'(8 + 4 * k));
      cycle();
    end
    rd1 = 1'b0;
    chk("wrap_empty", rv1, 0);
    push(32'h18);
    push(32'h1C);
    chk("frozen_drop", d0, 1);
    chk("frozen_count", c0, 4);
    chk("frozen_pc", rp0, 0);
    chk("sat_drop", d2, 3);
    chk("sat_ovf", ov2, 1);
    chk("sat_count", c2, 2);

    // full with simultaneous push and pop
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(32'h40 + 4 * i));
    chk("full0", c0, 4);
    valid = 1'b1; pc = 32'h50; rd0 = 1'b1; rd1 = 1'b1;
    cycle();
    valid = 1'b0; rd1 = 1'b0;
    chk("pp_count0", c0, 4);
    chk("pp_ovf0", ov0, 0);
    chk("pp_drop0", d0, 0);
    chk("pp_pc0", rp0, 32'h44);
    chk("pp_state0", s0, 2);
    chk("pp_count1", c1, 4);
    chk("pp_ovf1", ov1, 0);
    chk("pp_pc1", rp1, 32'h44);
    for (int k = 0; k < 3; k++) cycle();
    rd0 = 1'b0;
    chk("pp_last_pc", rp0, 32'h50);
    chk("pp_last_count", c0, 1);

    // clear beats a same-cycle push
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    push(32'h60); push(32'h64); push(32'h68);
    chk("pre_clear_count", c0, 3);
    clear = 1'b1; valid = 1'b1; pc = 32'h6C;
    cycle();
    clear = 1'b0; valid = 1'b0;
    chk("clr_count", c0, 0);
    chk("clr_state", s0, 1);
    chk("clr_valid", rv0, 0);
    cycle();
    chk("clr_not_stored", c0, 0);

    // disable retains contents; IDLE ignores valid but still pops
    push(32'h70);
    chk("cap_again", s0, 2);
    trace_en = 1'b0;
    cycle();
    chk("idle_state", s0, 0);
    chk("idle_retain", c0, 1);
    chk("idle_pc", rp0, 32'h70);
    push(32'h74);
    chk("idle_ignore", c0, 1);
    chk("idle_no_drop", d0, 0);
    rd0 = 1'b1;
    cycle();
    chk("idle_pop", c0, 0);
    cycle();
    rd0 = 1'b0;
    chk("empty_pop", c0, 0);
    chk("empty_valid", rv0, 0);

    // asynchronous reset mid-capture
    trace_en = 1'b1;
    cycle();
    push(32'h80);
    push(32'h84);
    chk("pre_rst_count", c0, 2);
    chk("pre_rst_count2", c2, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_state", s0, 0);
    chk("arst_count", c0, 0);
    chk("arst_valid", rv0, 0);
    chk("arst_count2", c2, 0);
    chk("arst_ovf2", ov2, 0);
    trace_en = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    push(32'h88);
    chk("post_rst_idle", s0, 0);
    chk("post_rst_count", c0, 0);
    trace_en = 1'b1;
    cycle();
    chk("rearm", s0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cv32e40p_trace_buffer.md
CV32E40P_TRACE_BUFFER -- requirements
Module: cv32e40p_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries (power of two, >=2).
REQ-002 SHALL have parameter WRAP, default 0: 0 = stop capture when full; 1 = overwrite oldest entry when full.
REQ-003 SHALL have parameter DROP_W, default 16, width of the dropped-record counter.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 trace_en_i  input  1  level; arms capture when high, returns to IDLE when low.
REQ-007 trigger_en_i  input  1  1 = wait for PC match before capturing; 0 = capture immediately.
REQ-008 trigger_pc_i  input  32  trigger PC value.
REQ-009 valid_i  input  1  one retired instruction this cycle.
REQ-010 pc_i, instr_i, wdata_i  input  32 each  record fields of the retired instruction.
REQ-011 clear_i  input  1  synchronous flush.
REQ-012 rd_req_i  input  1  pop request from the reader.
REQ-013 rd_valid_o  output  1  oldest entry present.
REQ-014 rd_pc_o, rd_instr_o, rd_wdata_o  output  32 each  fields of the oldest entry (show-ahead).
REQ-015 count_o  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-016 overflow_o  output  1  sticky; at least one record was lost or overwritten.
REQ-017 drop_cnt_o  output  DROP_W  saturating count of lost or overwritten records.
REQ-018 state_o  output  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN.

Function
REQ-019 SHALL implement FSM transitions:
- IDLE->ARMED when trace_en_i=1.
- ARMED->CAPTURE on a capture event.
- CAPTURE->FROZEN on a push that is dropped while full (WRAP=0 only).
- Any state->IDLE when trace_en_i=0.
REQ-020 Capture event in ARMED SHALL be valid_i && (!trigger_en_i || pc_i==trigger_pc_i); the triggering record SHALL itself be stored.
REQ-021 In CAPTURE every valid_i cycle SHALL be a push; in IDLE and FROZEN valid_i SHALL be ignored and SHALL NOT count as dropped.
REQ-022 Pop SHALL occur when rd_req_i && rd_valid_o; rd_req_i with count 0 SHALL have no effect.
REQ-023 rd_valid_o SHALL equal (count_o!=0); outputs SHALL be combinational from storage at the read pointer, with zero-cycle read latency.
REQ-024 A push SHALL be visible on rd_* and count_o in the cycle after the push edge.
REQ-025 Simultaneous push and pop with count between 1 and DEPTH SHALL leave count unchanged, with both pointers advancing.
REQ-026 A push when count=0 with rd_req_i=1 SHALL store the record; no pop occurs.
REQ-027 WRAP=0, full, push without pop: the record SHALL be dropped, overflow_o set, drop_cnt_o incremented, and the state SHALL go to FROZEN.
REQ-028 WRAP=1, full, push without pop: the record SHALL overwrite the oldest entry, both pointers SHALL advance, count SHALL stay DEPTH, overflow_o SHALL be set and drop_cnt_o incremented.
REQ-029 Full with simultaneous push and pop: the pop SHALL take effect first, then the push; there SHALL be no drop in either mode.
REQ-030 drop_cnt_o SHALL saturate at 2^DROP_W-1, and overflow_o SHALL remain 1.
REQ-031 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-032 Pops SHALL remain allowed in every state, including IDLE and FROZEN; buffer contents SHALL be retained on entry to IDLE.
REQ-033 clear_i SHALL zero the pointers, count, overflow_o and drop_cnt_o, and set the state to ARMED if trace_en_i=1, otherwise IDLE.
REQ-034 clear_i SHALL take priority over a push or pop in the same cycle; that record SHALL be discarded and not counted.
REQ-035 trace_en_i=0 SHALL take priority over every FSM transition except the register zeroing performed by clear_i.

Reset
REQ-036 While rst_ni=0, asynchronously:
- state_o=IDLE, count_o=0, rd_valid_o=0, overflow_o=0, drop_cnt_o=0, pointers=0.
REQ-037 Entry storage SHALL NOT require reset; rd_pc_o, rd_instr_o and rd_wdata_o are don't-care while rd_valid_o=0.
REQ-038 Reset asserted mid-capture SHALL discard all entries; after deassertion the block SHALL need trace_en_i high to re-arm.

Verification
REQ-039 trigger_en_i=1, trigger_pc_i=0x100, retire PCs 0xF8, 0xFC, 0x100, 0x104 -> only 0x100 and 0x104 stored; count_o=2, rd_pc_o=0x100.
REQ-040 DEPTH=4, WRAP=0, 6 pushes, no pops -> count_o=4, drop_cnt_o=1, state_o=FROZEN; further valid_i does not change drop_cnt_o; rd_pc_o equals the 1st PC.
REQ-041 DEPTH=4, WRAP=1, push PCs 0x0..0x14 step 4 -> count_o=4, drop_cnt_o=2, overflow_o=1; pops return 0x8, 0xC, 0x10, 0x14.
REQ-042 Full buffer with push and pop in the same cycle (both modes) -> count_o stays 4, no overflow, next pop returns the former 2nd entry.
REQ-043 DROP_W=2, WRAP=1, DEPTH=2, 8 pushes -> drop_cnt_o saturates at 3.
REQ-044 clear_i with valid_i=1 and trace_en_i=1 at count 3 -> count_o=0, state_o=ARMED, record not stored; rst_ni pulse mid-capture -> all outputs at reset values immediately.
